// File: rtl/cachewbbuf_pkg.sv
// cachewbbuf_pkg: shared types and default widths for the write-back buffer.
//   - default parameter values of the buffer
//   - derived widths for those defaults (OFFSETLEN, LOGBWPL, LOGDEPTH)
//   - drain FSM state encoding, also exported on the debug port
package cachewbbuf_pkg;

  localparam int PA_BITS_DEF = 56;
  localparam int LINELEN_DEF = 512;
  localparam int AHBW_DEF    = 64;
  localparam int DEPTH_DEF   = 4;

  // Byte-offset bits inside a line, beat-index bits, pointer bits.
  localparam int OFFSETLEN = $clog2(LINELEN_DEF / 8);
  localparam int LOGBWPL   = $clog2(LINELEN_DEF / AHBW_DEF);
  localparam int LOGDEPTH  = $clog2(DEPTH_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wb_state_e;

  // Offset width for an arbitrary line length (bits).
  function automatic int line_offset_bits(input int linelen);
    return $clog2(linelen / 8);
  endfunction

endpackage

// File: rtl/cachewbentry.sv
// cachewbentry: one slot of the write-back buffer.
//   Holds valid, line address and line data, and compares the stored line
//   address against the alloc address (for coalescing) and the probe address.
// Ports:
//   clk, reset        clock, async active-high reset
//   set_i             load a fresh line (valid, address, data)
//   upd_i             overwrite data only (coalesce)
//   clr_i             clear valid (pop)
//   alloc_adr_i/line  incoming line address and data
//   probe_adr_i       miss address to compare
//   valid_o, adr_o, line_o   stored state (adr_o is the line address only)
//   probe_hit_o, alloc_hit_o valid entry whose line matches probe / alloc
module cachewbentry #(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int OFF_W   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_i,
  input  logic                     upd_i,
  input  logic                     clr_i,
  input  logic [PA_BITS-1:0]       alloc_adr_i,
  input  logic [LINELEN-1:0]       alloc_line_i,
  input  logic [PA_BITS-1:0]       probe_adr_i,
  output logic                     valid_o,
  output logic [PA_BITS-OFF_W-1:0] adr_o,
  output logic [LINELEN-1:0]       line_o,
  output logic                     probe_hit_o,
  output logic                     alloc_hit_o
);

  localparam int LA_W = PA_BITS - OFF_W;

  logic              valid_q, valid_d;
  logic [LA_W-1:0]   adr_q, adr_d;
  logic [LINELEN-1:0] line_q, line_d;

  // Byte-offset bits never take part in a line match.
  logic unused_offs;
  assign unused_offs = ^{alloc_adr_i[OFF_W-1:0], probe_adr_i[OFF_W-1:0]};

  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    line_d  = line_q;
    if (set_i) begin
      valid_d = 1'b1;
      adr_d   = alloc_adr_i[PA_BITS-1:OFF_W];
      line_d  = alloc_line_i;
    end else begin
      if (upd_i) line_d  = alloc_line_i;
      if (clr_i) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      adr_q   <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      adr_q   <= adr_d;
      line_q  <= line_d;
    end
  end

  assign valid_o     = valid_q;
  assign adr_o       = adr_q;
  assign line_o      = line_q;
  assign probe_hit_o = valid_q & (adr_q == probe_adr_i[PA_BITS-1:OFF_W]);
  assign alloc_hit_o = valid_q & (adr_q == alloc_adr_i[PA_BITS-1:OFF_W]);

endmodule

// File: rtl/cachewbbuf.sv
// cachewbbuf: multi-entry write-back (victim) buffer between D$ and AHB.
//   Evicted dirty lines are accepted in one cycle into a circular FIFO and
//   drained beat by beat to the bus, deferring to pending line fetches unless
//   the buffer is full or a flush is requested. Misses probe all entries so
//   a buffered line is forwarded instead of stale memory data.
// Handshake: an alloc is taken on a rising edge where AllocValid & AllocReady;
//   a bus beat completes on a rising edge where BusReq & BusBeatAck, and
//   BusAdr/BusWriteData hold steady while BusReq is high and no ack arrives.
// Ports:
//   clk, reset                         clock, async active-high reset
//   AllocValid/AllocAdr/AllocLine      evicted line in; AllocReady = not full
//   ProbeAdr -> ProbeHit/ProbeLine     combinational lookup
//   FetchPending, FlushDrain           drain arbitration
//   BusReq/BusAdr/BusBeat/BusWriteData write beat out; BusBeatAck in
//   Empty, Count                       occupancy
//   DbgState                           drain FSM state
module cachewbbuf
  import cachewbbuf_pkg::*;
#(
  parameter int PA_BITS = PA_BITS_DEF,
  parameter int LINELEN = LINELEN_DEF,
  parameter int AHBW    = AHBW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              AllocValid,
  input  logic [PA_BITS-1:0]                AllocAdr,
  input  logic [LINELEN-1:0]                AllocLine,
  output logic                              AllocReady,
  input  logic [PA_BITS-1:0]                ProbeAdr,
  output logic                              ProbeHit,
  output logic [LINELEN-1:0]                ProbeLine,
  input  logic                              FetchPending,
  input  logic                              FlushDrain,
  output logic                              BusReq,
  output logic [PA_BITS-1:0]                BusAdr,
  output logic [$clog2(LINELEN/AHBW)-1:0]   BusBeat,
  output logic [AHBW-1:0]                   BusWriteData,
  input  logic                              BusBeatAck,
  output logic                              Empty,
  output logic [$clog2(DEPTH):0]            Count,
  output wb_state_e                         DbgState
);

  localparam int OFF_W  = $clog2(LINELEN / 8);
  localparam int BEAT_W = $clog2(LINELEN / AHBW);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LA_W   = PA_BITS - OFF_W;
  localparam int NBEATS = LINELEN / AHBW;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  wb_state_e           state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic [DEPTH-1:0]    ent_valid, ent_probe_hit, ent_alloc_hit;
  logic [DEPTH-1:0]    ent_set, ent_upd, ent_clr;
  logic [LA_W-1:0]     ent_adr [DEPTH];
  logic [LINELEN-1:0]  ent_line [DEPTH];

  logic full, empty, alloc_acc, append, pop;
  logic co_hit, pr_hit;
  logic [PTR_W-1:0] co_idx, pr_idx, co_scan, pr_scan;
  logic [LINELEN-1:0] head_line;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign alloc_acc = AllocValid & ~full;

  // Coalesce target: the youngest valid entry with the alloc's line address,
  // skipping a head that is already on the bus (its data must stay frozen).
  always_comb begin
    co_hit  = 1'b0;
    co_idx  = '0;
    co_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      co_scan = head_q + PTR_W'(k);
      if (ent_alloc_hit[co_scan] && !(k == 0 && state_q == ST_DRAIN)) begin
        co_hit = 1'b1;
        co_idx = co_scan;
      end
    end
  end

  // Probe priority: scan from head towards tail so the youngest match wins
  // (only the draining head and its appended copy can both match).
  always_comb begin
    pr_hit  = 1'b0;
    pr_idx  = '0;
    pr_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pr_scan = head_q + PTR_W'(k);
      if (ent_probe_hit[pr_scan]) begin
        pr_hit = 1'b1;
        pr_idx = pr_scan;
      end
    end
  end

  assign append = alloc_acc & ~co_hit;
  assign pop    = (state_q == ST_DRAIN) & BusBeatAck & (beat_q == LAST_BEAT);

  assign ent_set = append               ? (DEPTH'(1) << tail_q) : '0;
  assign ent_upd = (alloc_acc & co_hit) ? (DEPTH'(1) << co_idx) : '0;
  assign ent_clr = pop                  ? (DEPTH'(1) << head_q) : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    cachewbentry #(
      .PA_BITS (PA_BITS),
      .LINELEN (LINELEN),
      .OFF_W   (OFF_W)
    ) u_entry (
      .clk          (clk),
      .reset        (reset),
      .set_i        (ent_set[g]),
      .upd_i        (ent_upd[g]),
      .clr_i        (ent_clr[g]),
      .alloc_adr_i  (AllocAdr),
      .alloc_line_i (AllocLine),
      .probe_adr_i  (ProbeAdr),
      .valid_o      (ent_valid[g]),
      .adr_o        (ent_adr[g]),
      .line_o       (ent_line[g]),
      .probe_hit_o  (ent_probe_hit[g]),
      .alloc_hit_o  (ent_alloc_hit[g])
    );
  end

  // Drain FSM. An alloc arriving into an empty buffer may start the drain on
  // the same edge: head == tail, so the new line is the head next cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if ((~empty | alloc_acc) & (~FetchPending | full | FlushDrain))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (BusBeatAck) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    head_d  = pop    ? head_q + 1'b1 : head_q;
    tail_d  = append ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {{PTR_W{1'b0}}, append} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end

  assign head_line    = ent_line[head_q];
  assign AllocReady   = ~full;
  assign ProbeHit     = pr_hit;
  assign ProbeLine    = pr_hit ? ent_line[pr_idx] : '0;
  assign BusReq       = (state_q == ST_DRAIN);
  assign BusBeat      = beat_q;
  assign BusAdr       = {ent_adr[head_q], {OFF_W{1'b0}}};
  assign BusWriteData = head_line[int'(beat_q)*AHBW +: AHBW];
  assign Empty        = empty;
  assign Count        = count_q;
  assign DbgState     = state_q;

endmodule

// File: tb/tb_cachewbbuf.sv
// Bench for cachewbbuf: directed scenarios, a queue-level reference model
// updated on each rising edge, and a per-cycle compare on the falling edge.
module tb_cachewbbuf;

  localparam int PA = 56;
  localparam int LL = 512;
  localparam int BW = 64;
  localparam int DEPTH = 4;
  localparam int NB = LL / BW;
  localparam int OFF = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           AllocValid = 1'b0;
  logic [PA-1:0]  AllocAdr = '0;
  logic [LL-1:0]  AllocLine = '0;
  logic           AllocReady;
  logic [PA-1:0]  ProbeAdr = '0;
  logic           ProbeHit;
  logic [LL-1:0]  ProbeLine;
  logic           FetchPending = 1'b0;
  logic           FlushDrain = 1'b0;
  logic           BusReq;
  logic [PA-1:0]  BusAdr;
  logic [2:0]     BusBeat;
  logic [BW-1:0]  BusWriteData;
  logic           BusBeatAck = 1'b0;
  logic           Empty;
  logic [2:0]     Count;
  cachewbbuf_pkg::wb_state_e dbg_state;

  cachewbbuf #(.PA_BITS(PA), .LINELEN(LL), .AHBW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .AllocValid(AllocValid), .AllocAdr(AllocAdr), .AllocLine(AllocLine),
    .AllocReady(AllocReady),
    .ProbeAdr(ProbeAdr), .ProbeHit(ProbeHit), .ProbeLine(ProbeLine),
    .FetchPending(FetchPending), .FlushDrain(FlushDrain),
    .BusReq(BusReq), .BusAdr(BusAdr), .BusBeat(BusBeat),
    .BusWriteData(BusWriteData), .BusBeatAck(BusBeatAck),
    .Empty(Empty), .Count(Count), .DbgState(dbg_state)
  );

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered lines oldest-first, plus the drain in progress.
  logic [PA-OFF-1:0] mla[$];
  logic [LL-1:0]     mdata[$];
  logic [BW-1:0]     exp_q[$];   // beats still owed for the line on the bus
  bit m_drain = 1'b0;
  int m_beat = 0;

  int  u_sz;
  bit  u_acc, u_pop, u_start, u_found;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mla.delete(); mdata.delete(); exp_q.delete();
      m_drain = 1'b0; m_beat = 0;
    end else begin
      u_sz    = mla.size();
      u_acc   = AllocValid && (u_sz < DEPTH);
      u_pop   = m_drain && BusBeatAck && (m_beat == NB - 1);
      u_start = !m_drain && (u_sz > 0 || u_acc) &&
                (!FetchPending || u_sz == DEPTH || FlushDrain);
      if (u_acc) begin
        u_found = 1'b0;
        for (int j = u_sz - 1; j >= (m_drain ? 1 : 0); j--)
          if (!u_found && mla[j] == AllocAdr[PA-1:OFF]) begin
            mdata[j] = AllocLine;
            u_found = 1'b1;
          end
        if (!u_found) begin
          mla.push_back(AllocAdr[PA-1:OFF]);
          mdata.push_back(AllocLine);
        end
      end
      if (m_drain && BusBeatAck) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_beat++;
        if (u_pop) begin
          void'(mla.pop_front());
          void'(mdata.pop_front());
          m_drain = 1'b0;
          m_beat = 0;
        end
      end
      if (u_start) begin
        m_drain = 1'b1;
        m_beat = 0;
        for (int b = 0; b < NB; b++) exp_q.push_back(mdata[0][b*BW +: BW]);
      end
    end
  end

  // Per-cycle compare against the model.
  int c_sz;
  logic c_hit;
  logic [LL-1:0] c_line;
  initial forever begin
    @(negedge clk);
    if (!reset && chk_en) begin
      c_sz = mla.size();
      c_hit = 1'b0;
      c_line = '0;
      for (int j = 0; j < c_sz; j++)
        if (mla[j] == ProbeAdr[PA-1:OFF]) begin
          c_hit = 1'b1;
          c_line = mdata[j];
        end
      chk("m_ready", AllocReady, c_sz < DEPTH);
      chk("m_empty", Empty, c_sz == 0);
      chk("m_count", Count, c_sz);
      chk("m_probehit", ProbeHit, c_hit);
      chk("m_probeline", ProbeLine, c_line);
      chk("m_busreq", BusReq, m_drain);
      chk("m_beat", BusBeat, m_drain ? m_beat : 0);
      chk("m_state", dbg_state, m_drain);
      if (m_drain) begin
        chk("m_busadr", BusAdr, {mla[0], 6'b0});
        if (exp_q.size() > 0) chk("m_wdata", BusWriteData, exp_q[0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [PA-1:0] adr, input logic [LL-1:0] line);
    AllocValid = 1'b1;
    AllocAdr = adr;
    AllocLine = line;
    tick();
    AllocValid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Empty && !BusReq) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_empty", done, 1'b1);
  endtask

  function automatic logic [LL-1:0] make_line(input logic [31:0] seed);
    logic [LL-1:0] l;
    for (int b = 0; b < NB; b++)
      l[b*BW +: BW] = 64'(b) * 64'h0101_0101_0101_0101 + {seed, 32'h0};
    return l;
  endfunction

  logic [LL-1:0] da, d1, d2, dc, dc2;

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk_en = 1'b1;

    // Reset values
    chk("rst_ready", AllocReady, 1'b1);
    chk("rst_probehit", ProbeHit, 1'b0);
    chk("rst_probeline", ProbeLine, '0);
    chk("rst_busreq", BusReq, 1'b0);
    chk("rst_busadr", BusAdr, '0);
    chk("rst_beat", BusBeat, '0);
    chk("rst_wdata", BusWriteData, '0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_count", Count, '0);

    // Single line, acked every cycle
    FetchPending = 1'b0;
    BusBeatAck = 1'b1;
    do_alloc(56'h8000_0040, make_line(32'h0));
    chk("t1_busreq", BusReq, 1'b1);
    chk("t1_busadr", BusAdr, 56'h8000_0040);
    chk("t1_beat0", BusBeat, 3'd0);
    repeat (3) tick();
    chk("t1_beat3", BusBeat, 3'd3);
    chk("t1_wdata3", BusWriteData, 64'h0303_0303_0303_0303);
    repeat (5) tick();
    chk("t1_empty", Empty, 1'b1);
    chk("t1_busreq_off", BusReq, 1'b0);

    // Fill while a fetch is pending; full forces the drain
    BusBeatAck = 1'b0;
    FetchPending = 1'b1;
    for (int i = 0; i < 4; i++) do_alloc(56'h2000 + 56'(i * 64), make_line(32'h10 + i));
    chk("t2_ready_full", AllocReady, 1'b0);
    chk("t2_count4", Count, 3'd4);
    chk("t2_noreq", BusReq, 1'b0);
    tick();
    chk("t2_forced", BusReq, 1'b1);
    chk("t2_adr", BusAdr, 56'h2000);
    BusBeatAck = 1'b1;
    repeat (8) tick();
    chk("t2_ready_back", AllocReady, 1'b1);
    chk("t2_count3", Count, 3'd3);
    tick();
    chk("t2_defer", BusReq, 1'b0);
    FetchPending = 1'b0;
    wait_empty(100);

    // Probe forwarding within the same line
    BusBeatAck = 1'b0;
    FetchPending = 1'b1;
    da = make_line(32'hA);
    do_alloc(56'h1000, da);
    ProbeAdr = 56'h1020;
    #1;
    chk("t3_hit", ProbeHit, 1'b1);
    chk("t3_line", ProbeLine, da);
    FetchPending = 1'b0;
    BusBeatAck = 1'b1;
    wait_empty(40);
    ProbeAdr = 56'h1000;
    #1;
    chk("t3_miss", ProbeHit, 1'b0);
    chk("t3_missline", ProbeLine, '0);

    // Coalesce into an idle head; flush drains despite pending fetch
    BusBeatAck = 1'b0;
    FetchPending = 1'b1;
    d1 = make_line(32'hB1);
    d2 = make_line(32'hB2);
    do_alloc(56'h3000, d1);
    do_alloc(56'h3000, d2);
    chk("t4_count1", Count, 3'd1);
    FlushDrain = 1'b1;
    tick();
    chk("t4_req", BusReq, 1'b1);
    chk("t4_wdata", BusWriteData, d2[63:0]);
    BusBeatAck = 1'b1;
    wait_empty(40);
    FlushDrain = 1'b0;
    FetchPending = 1'b0;

    // Re-alloc of the line currently on the bus appends a new entry
    BusBeatAck = 1'b0;
    dc = make_line(32'hC1);
    dc2 = make_line(32'hC2);
    do_alloc(56'h4000, dc);
    chk("t5_req", BusReq, 1'b1);
    BusBeatAck = 1'b1;
    repeat (2) tick();
    do_alloc(56'h4000, dc2);
    chk("t5_count2", Count, 3'd2);
    chk("t5_beat3", BusBeat, 3'd3);
    chk("t5_olddata", BusWriteData, dc[3*BW +: BW]);
    ProbeAdr = 56'h4000;
    #1;
    chk("t5_probe_new", ProbeLine, dc2);
    wait_empty(60);

    // Reset in the middle of a drain
    BusBeatAck = 1'b1;
    do_alloc(56'h5000, make_line(32'hD));
    repeat (3) tick();
    chk("t6_beat3", BusBeat, 3'd3);
    reset = 1'b1;
    #1;
    chk("t6_req_drop", BusReq, 1'b0);
    chk("t6_count0", Count, '0);
    chk("t6_empty", Empty, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    do_alloc(56'h6000, make_line(32'hE));
    chk("t6_req_again", BusReq, 1'b1);
    chk("t6_beat_zero", BusBeat, 3'd0);
    chk("t6_adr", BusAdr, 56'h6000);
    wait_empty(40);

    chk_en = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
